// File: rtl/game_keys_pkg.sv
// Shared key constants and sequencer types for the keyboard front end and the game FSM.
package game_keys_pkg;

    localparam logic [7:0] KEY_NONE    = 8'h00;
    localparam logic [7:0] KEY_ESC     = 8'h29;
    localparam logic [7:0] KEY_SPACE   = 8'h2C;
    localparam logic [7:0] KEY_P1_BOMB = 8'h13;
    localparam logic [7:0] KEY_P2_BOMB = 8'h19;
    localparam logic [7:0] KEY_RESTART = 8'h1F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_fifo.sv
// Press-event queue: accepts several pushes per cycle, one pop, and drops pushes that do not fit.
module key_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_SLOTS  = 4
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic [$clog2(NUM_SLOTS+1)-1:0]   push_cnt,
    input  logic [8*NUM_SLOTS-1:0]           push_data,
    input  logic                             pop,
    output logic [7:0]                       head,
    output logic [$clog2(FIFO_DEPTH):0]      count,
    output logic                             drop
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          pop_ok;
    int            after_pop;
    int            space;
    int            accept;

    // The pop frees its slot before this edge's pushes are sized against the space left.
    always_comb begin
        pop_ok    = pop && (count != '0);
        after_pop = int'(count) - (pop_ok ? 1 : 0);
        space     = FIFO_DEPTH - after_pop;
        accept    = (int'(push_cnt) > space) ? space : int'(push_cnt);
        drop      = int'(push_cnt) > space;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(pop_ok);
            wr_ptr <= wr_ptr + AW'(accept);
            count  <= CW'(after_pop + accept);
        end
    end

    always_ff @(posedge Clk) begin
        for (int j = 0; j < NUM_SLOTS; j++) begin
            if (j < accept) begin
                mem[AW'(int'(wr_ptr) + j)] <= push_data[8*j +: 8];
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/key_event_gen.sv
// Turns raw keyboard reports into single, separated keycode press events for the game FSM.
module key_event_gen
    import game_keys_pkg::*;
#(
    parameter int NUM_SLOTS   = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          report_valid,
    input  logic [8*NUM_SLOTS-1:0]        keys_in,
    output logic [7:0]                    keycode,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int PW   = $clog2(NUM_SLOTS + 1);
    localparam int CNTW = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES)) + 1;

    logic [8*NUM_SLOTS-1:0] prev_keys;
    logic [NUM_SLOTS-1:0]   new_mask;
    logic [PW-1:0]          push_cnt;
    logic [8*NUM_SLOTS-1:0] push_data;
    logic                   pop;
    logic [7:0]             fifo_head;
    logic                   fifo_drop;
    logic [7:0]             hold_key;
    seq_state_t             state;
    seq_state_t             state_next;
    logic [CNTW-1:0]        cnt;
    logic [CNTW-1:0]        cnt_next;

    // A slot is new only if the previous report lacked it and no lower slot already claimed it.
    always_comb begin
        new_mask = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            new_mask[i] = report_valid && (keys_in[8*i +: 8] != KEY_NONE);
            for (int j = 0; j < NUM_SLOTS; j++) begin
                if (prev_keys[8*j +: 8] == keys_in[8*i +: 8]) new_mask[i] = 1'b0;
            end
            for (int j = 0; j < i; j++) begin
                if (keys_in[8*j +: 8] == keys_in[8*i +: 8]) new_mask[i] = 1'b0;
            end
        end
    end

    always_comb begin
        push_cnt  = '0;
        push_data = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (new_mask[i]) begin
                push_data[8*push_cnt +: 8] = keys_in[8*i +: 8];
                push_cnt = push_cnt + PW'(1);
            end
        end
    end

    key_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .NUM_SLOTS  (NUM_SLOTS)
    ) u_fifo (
        .Clk       (Clk),
        .Reset     (Reset),
        .push_cnt  (push_cnt),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .drop      (fifo_drop)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pop        = 1'b0;
        unique case (state)
            IDLE: if (fifo_count != '0) begin
                pop        = 1'b1;
                cnt_next   = CNTW'(HOLD_CYCLES - 1);
                state_next = HOLD;
            end
            HOLD: if (cnt == '0) begin
                cnt_next   = CNTW'(GAP_CYCLES - 1);
                state_next = GAP;
            end else begin
                cnt_next = cnt - CNTW'(1);
            end
            GAP: if (cnt == '0) begin
                state_next = IDLE;
            end else begin
                cnt_next = cnt - CNTW'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered from the current state, so they trail the state by one cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            keycode   <= KEY_NONE;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            prev_keys <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            keycode <= (state == HOLD) ? hold_key : KEY_NONE;
            busy    <= (state != IDLE);
            if (fifo_drop)    overflow  <= 1'b1;
            if (report_valid) prev_keys <= keys_in;
        end
    end

    always_ff @(posedge Clk) begin
        if (pop) hold_key <= fifo_head;
    end

endmodule

// File: doc/key_event_gen.md
Name: key_event_gen

Overview:
- Producer side of the 8-bit `keycode` bus that feeds the game state machine.
- Takes raw keyboard reports (up to 4 simultaneous keycodes per report) and detects newly pressed keys.
- Queues new presses and replays them one at a time on a single `keycode` output.
- Each press is held long enough to be seen, followed by a 0x00 gap, so every press is a distinct event. Held keys never retrigger.

Parameters:
- NUM_SLOTS, 4, keycode slots per report.
- FIFO_DEPTH, 4, press-event queue depth; must be a power of two, at least 2.
- HOLD_CYCLES, 2, cycles each queued keycode is driven (at least 1).
- GAP_CYCLES, 1, cycles of 0x00 driven after each hold (at least 1).

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- report_valid  in  1  one-cycle strobe: keys_in holds a new report
- keys_in  in  8*NUM_SLOTS  packed slots; slot i = keys_in[8i+7:8i]; 0x00 = empty slot
- keycode  out  8  replayed press event to the game FSM; 0x00 = none
- busy  out  1  1 while in HOLD or GAP
- fifo_count  out  $clog2(FIFO_DEPTH)+1  queued events
- overflow  out  1  sticky: at least one press was dropped

Behaviour:
- One clock domain. Reset is synchronous and active-high on Clk, named Reset.
- Reset values:
  - keycode = 0x00, busy = 0, fifo_count = 0, overflow = 0.
  - Sequencer in IDLE, previous-report register all 0x00, counters 0.
- Press detection (on a Clk edge with report_valid = 1):
  - Slot i is a new press if it is nonzero, absent from every slot of the previous report, and not equal to any lower-numbered slot of this report (duplicates collapse).
  - New presses are pushed in ascending slot order, up to NUM_SLOTS pushes in one cycle.
  - The previous-report register loads keys_in on the same edge.
  - With report_valid = 0, nothing is pushed and the previous report is kept.
- Release: a key missing from the new report is forgotten silently. A later reappearance is a new press.
- Queue full:
  - New presses are accepted in slot order until the queue is full; the rest are dropped.
  - overflow is set on that edge and stays set until Reset.
- Same-edge push and pop:
  - The pop is evaluated against the pre-edge count; pushes are then accepted against (count − pop).
  - Pop and push together on a full queue therefore accepts one push.
- Sequencer states:
  - IDLE: keycode = 0x00. If fifo_count > 0, pop the head, load the hold counter, go to HOLD.
  - HOLD: keycode = popped value for exactly HOLD_CYCLES cycles, then GAP.
  - GAP: keycode = 0x00 for exactly GAP_CYCLES cycles, then IDLE.
- Timing:
  - keycode and busy are registered.
  - Latency: report_valid sampled at edge E with an empty queue and IDLE sequencer → keycode valid after edge E+2.
  - Back-to-back events repeat every HOLD_CYCLES + GAP_CYCLES + 1 cycles.
- Reset mid-HOLD: keycode = 0x00 after the reset edge; the queue is flushed and the previous report cleared. A key still held after reset is therefore a new press on the next report.
- Arithmetic:
  - FIFO pointers wrap modulo FIFO_DEPTH.
  - fifo_count is never above FIFO_DEPTH and never below 0.
  - Hold/gap counters are sized $clog2(max(HOLD_CYCLES, GAP_CYCLES))+1.

Decomposition:
- Package game_keys_pkg:
  - KEY_NONE = 8'h00, KEY_ESC = 8'h29, KEY_SPACE = 8'h2C.
  - P1/P2 bomb keys 8'h13 and 8'h19; restart key 8'h1F.
  - Sequencer state enum {IDLE, HOLD, GAP}.
- The game state machine imports the same key constants.
- Sub-module key_fifo:
  - Synchronous FIFO, 8-bit data, FIFO_DEPTH entries.
  - Multi-push port (count 0..NUM_SLOTS), single pop, count output, drop on full.
- New-press detection and the sequencer stay in key_event_gen.

Test Plan:
- Single press: report {0x2C,0,0,0} once → keycode 0x2C for 2 cycles starting 2 cycles after the strobe, then 0x00; fifo_count returns to 0.
- Held key: reports {0x13,0,0,0} ×5 consecutive → exactly one 0x13 event. Then {0,0,0,0}, then {0x13,0,0,0} → a second 0x13 event.
- Multi-key, duplicates: report {0x13,0x19,0x13,0x29} → events 0x13, 0x19, 0x29 in order, each 2 hold + 1 gap cycles; no duplicate 0x13.
- Overflow: report {0x04,0x05,0x06,0x07}, then on the next cycle {0x04,0x05,0x06,0x07,…} with new slot keys {0x08,0x09,0x0A,0x0B} before any pop → 0x04–0x07 replay. The second-report keys are accepted only up to the free space (one slot after the first pop); overflow = 1 and stays 1.
- Same-edge push/pop: queue holds 4 entries, sequencer in IDLE, report with one new key → pop and push on the same edge; fifo_count stays 4; no overflow.
- Reset mid-HOLD: assert Reset while keycode = 0x19 → keycode 0x00, fifo_count 0, overflow 0 after the edge. Report {0x19,0,0,0} afterwards → a new 0x19 event.
